// File: rtl/uart_pkg.sv
// uart_pkg: shared UART types, default timing constants and frame-length helper
//   tx_state_e          transmitter FSM states
//   DEF_CLKS_PER_BIT    clocks per bit at 3.2256 MHz / 115200 baud
//   DEF_DATA_BITS       payload bits per frame
//   frame_cycles()      total clocks in one start+data+stop frame
package uart_pkg;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_e;
  localparam int DEF_CLKS_PER_BIT = 28;
  localparam int DEF_DATA_BITS = 8;
  function automatic int frame_cycles(input int data_bits, input int stop_bits, input int clks_per_bit);
    return (1 + data_bits + stop_bits) * clks_per_bit;
  endfunction
endpackage

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: synchronous byte FIFO feeding the UART transmitter
//   i_clk, i_rst_n   clock, asynchronous active-low reset (flushes pointers/count)
//   i_push, i_data   write request and data; ignored while full
//   i_pop, o_data    read request and head-of-queue data; ignored while empty
//   o_full, o_empty  occupancy flags
//   o_count          occupancy, one bit wider than the pointers
module uart_tx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic push_ok, pop_ok;
  // full is judged before this edge's pop, so a full FIFO never accepts
  assign o_full = o_count == (AW+1)'(DEPTH);
  assign o_empty = o_count == '0;
  assign push_ok = i_push && !o_full;
  assign pop_ok = i_pop && !o_empty;
  assign o_data = mem[rd_ptr];
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      o_count <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(push_ok);
      rd_ptr <= rd_ptr + AW'(pop_ok);
      o_count <= o_count + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
    end
  always_ff @(posedge i_clk)
    if (push_ok) mem[wr_ptr] <= i_data;
endmodule

// File: rtl/uart_tx.sv
// uart_tx: buffered 8N1 UART transmitter, LSB first, line idles high
//   i_clk, i_rst_n   UART clock, asynchronous active-low reset (aborts any frame)
//   i_data, i_valid  byte to send; accepted when i_valid && o_ready at posedge
//   o_ready          FIFO not full
//   o_tx             registered serial line
//   o_busy           frame in progress or bytes queued
//   o_fifo_cnt       FIFO occupancy
module uart_tx import uart_pkg::*; #(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int DATA_BITS = DEF_DATA_BITS,
  parameter int STOP_BITS = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic [DATA_BITS-1:0]          i_data,
  input  logic                          i_valid,
  output logic                          o_ready,
  output logic                          o_tx,
  output logic                          o_busy,
  output logic [$clog2(FIFO_DEPTH):0]   o_fifo_cnt
);
  localparam int BW = $clog2(STOP_BITS * CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_BITS);
  localparam logic [BW-1:0] BIT_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS * CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);
  tx_state_e state;
  logic [BW-1:0] baud;
  logic [IW-1:0] idx;
  logic [DATA_BITS-1:0] shift, head;
  logic full, empty, pop, baud_end;
  assign baud_end = baud == (state == STOP ? STOP_LAST : BIT_LAST);
  // pop from IDLE, or at the last stop cycle so the next start bit follows without a gap
  assign pop = !empty && (state == IDLE || (state == STOP && baud_end));
  assign o_ready = !full;
  assign o_busy = state != IDLE || !empty;
  uart_tx_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(DATA_BITS)) fifo (
    .i_clk(i_clk),
    .i_rst_n(i_rst_n),
    .i_push(i_valid),
    .i_data(i_data),
    .i_pop(pop),
    .o_data(head),
    .o_full(full),
    .o_empty(empty),
    .o_count(o_fifo_cnt)
  );
  // o_tx is updated on the same edge as the state so it always matches the bit being sent
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      state <= IDLE;
      baud <= '0;
      idx <= '0;
      shift <= '0;
      o_tx <= 1'b1;
    end else if (pop) begin
      state <= START;
      baud <= '0;
      shift <= head;
      o_tx <= 1'b0;
    end else if (state != IDLE) begin
      baud <= baud_end ? '0 : baud + 1'b1;
      if (baud_end)
        case (state)
          START: begin
            state <= DATA;
            idx <= '0;
            o_tx <= shift[0];
          end
          DATA:
            if (idx == IDX_LAST) begin
              state <= STOP;
              o_tx <= 1'b1;
            end else begin
              idx <= idx + 1'b1;
              shift <= shift >> 1;
              o_tx <= shift[1];
            end
          default: begin
            state <= IDLE;
            o_tx <= 1'b1;
          end
        endcase
    end
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: random-stimulus bench comparing two uart_tx instances (1 and 2 stop bits) to a frame-timing model
module tb_uart_tx;
  localparam int CPB = 28;
  localparam int DB = 8;
  localparam int D = 4;
  logic clk = 0;
  logic rst_n = 0;
  logic valid = 0;
  logic [7:0] data = 0;
  logic [1:0] ready, txl, busy;
  logic [2:0] cnt0, cnt1;
  int tests = 0;
  int fails = 0;
  int n[2], t[2], fl[2], rt[2], sh[2], st[2];
  logic [7:0] qd[2][D];
  logic [7:0] cur[2], rb[2];
  logic [7:0] sent[2][1024];
  bit acc[2];

  always #5 clk = ~clk;

  uart_tx #(.CLKS_PER_BIT(CPB), .DATA_BITS(DB), .STOP_BITS(1), .FIFO_DEPTH(D)) dut0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_data(data), .i_valid(valid),
    .o_ready(ready[0]), .o_tx(txl[0]), .o_busy(busy[0]), .o_fifo_cnt(cnt0));
  uart_tx #(.CLKS_PER_BIT(CPB), .DATA_BITS(DB), .STOP_BITS(2), .FIFO_DEPTH(D)) dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_data(data), .i_valid(valid),
    .o_ready(ready[1]), .o_tx(txl[1]), .o_busy(busy[1]), .o_fifo_cnt(cnt1));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic exp_tx(input int j);
    if (t[j] < 0 || t[j] >= CPB * (1 + DB)) return 1'b1;
    if (t[j] < CPB) return 1'b0;
    return cur[j][(t[j] - CPB) / CPB];
  endfunction

  task automatic tick();
    @(posedge clk);
    for (int j = 0; j < 2; j++)
      if (!rst_n) begin
        n[j] = 0; t[j] = -1; rt[j] = -1; sh[j] = st[j]; acc[j] = 0;
      end else begin
        acc[j] = valid && n[j] < D;
        if (t[j] >= 0) t[j]++;
        if (t[j] == fl[j]) t[j] = -1;
        if (t[j] < 0 && n[j] > 0) begin
          cur[j] = qd[j][0];
          for (int k = 0; k < D - 1; k++) qd[j][k] = qd[j][k+1];
          n[j]--;
          t[j] = 0;
        end
        if (acc[j]) begin
          qd[j][n[j]] = data;
          n[j]++;
          sent[j][st[j] % 1024] = data;
          st[j]++;
        end
      end
    #1;
    for (int j = 0; j < 2; j++) begin
      check($sformatf("tx%0d", j), 32'(txl[j]), 32'(exp_tx(j)));
      check($sformatf("ready%0d", j), 32'(ready[j]), 32'(n[j] < D));
      check($sformatf("busy%0d", j), 32'(busy[j]), 32'(t[j] >= 0 || n[j] > 0));
      check($sformatf("cnt%0d", j), j ? 32'(cnt1) : 32'(cnt0), 32'(n[j]));
      if (rst_n) begin
        if (rt[j] < 0) begin
          if (txl[j] == 1'b0) rt[j] = 0;
        end else begin
          rt[j]++;
          if (rt[j] == CPB / 2 + CPB * (1 + DB)) begin
            check($sformatf("stop%0d", j), 32'(txl[j]), 32'd1);
            if (sh[j] == st[j]) check($sformatf("rx_extra%0d", j), 32'd1, 32'd0);
            else begin
              check($sformatf("rx%0d", j), 32'(rb[j]), 32'(sent[j][sh[j] % 1024]));
              sh[j]++;
            end
            rt[j] = -1;
          end else if (rt[j] >= CPB + CPB / 2 && (rt[j] - CPB / 2) % CPB == 0)
            rb[j][(rt[j] - CPB / 2) / CPB - 1] = txl[j];
        end
      end
    end
  endtask

  task automatic idle(input int nc);
    valid = 0;
    repeat (nc) tick();
  endtask

  task automatic drain();
    int c = 0;
    valid = 0;
    while ((t[0] >= 0 || n[0] > 0 || t[1] >= 0 || n[1] > 0) && c < 4000) begin
      tick();
      c++;
    end
    repeat (20) tick();
    check("drain", 32'(c < 4000), 32'd1);
    for (int j = 0; j < 2; j++) check($sformatf("rx_all%0d", j), 32'(sh[j]), 32'(st[j]));
  endtask

  initial begin
    int a, got, guard;
    fl[0] = (1 + DB + 1) * CPB;
    fl[1] = (1 + DB + 2) * CPB;
    for (int j = 0; j < 2; j++) begin
      sh[j] = 0; st[j] = 0; rt[j] = -1; n[j] = 0; t[j] = -1;
    end
    repeat (2) tick();
    rst_n = 1;
    idle(2);
    valid = 1; data = 8'h55;
    tick();
    idle(340);
    valid = 1; data = 8'h00;
    tick();
    data = 8'hFF;
    tick();
    data = 8'hA5;
    tick();
    idle(950);
    valid = 1; data = 8'($urandom);
    a = 0;
    repeat (279) begin
      tick();
      a += int'(acc[0]);
      if (acc[0]) data = 8'($urandom);
    end
    check("hold_acc", 32'(a), 32'(D + 1));
    repeat (1200) begin
      tick();
      if (acc[0]) data = 8'($urandom);
    end
    drain();
    valid = 1; data = 8'h3C;
    tick();
    data = 8'($urandom);
    tick();
    data = 8'($urandom);
    tick();
    idle(CPB * 3);
    rst_n = 0;
    #1;
    check("rst_tx0", 32'(txl[0]), 32'd1);
    check("rst_tx1", 32'(txl[1]), 32'd1);
    check("rst_cnt0", 32'(cnt0), 32'd0);
    check("rst_cnt1", 32'(cnt1), 32'd0);
    check("rst_ready0", 32'(ready[0]), 32'd1);
    check("rst_busy0", 32'(busy[0]), 32'd0);
    repeat (3) tick();
    rst_n = 1;
    idle(400);
    got = 0;
    guard = 0;
    valid = 0;
    while (got < 192 && guard < 70000) begin
      if (!valid) begin
        valid = 1'($urandom);
        data = 8'($urandom);
      end
      tick();
      guard++;
      if (acc[0]) begin
        got++;
        valid = 0;
      end
    end
    check("rand_bound", 32'(guard < 70000), 32'd1);
    drain();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
